aes_decrypt: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 InvCipher) that computes one round per clock. It is the receive-side counterpart of the AES_Encrypt core: it consumes ciphertext and produces plaintext. Round keys come from the shared key-expansion storage through a 4-bit address and a 128-bit read port. The read port is asynchronous, so a key is valid in the same cycle as its address. Keys are walked from index 10 down to 0.

---
 rtl/aes_decrypt.sv | 162 ++++++++++++++++
 tb/tb_aes_decrypt.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys walked 10 down to 0
// from an external asynchronous key store, with stall on round_key_rdy.
module aes_decrypt #(
  parameter int unsigned NR     = 10,
  parameter int unsigned KEY_AW = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                En,
  input  logic [127:0]        data_in,
  input  logic [127:0]        round_key,
  input  logic                round_key_rdy,
  output logic [127:0]        data_out,
  output logic                done,
  output logic [KEY_AW-1:0]   round_key_addr
);

  localparam int unsigned BLK_W = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  state_t              r_fsm;
  state_t              w_fsm_nxt;
  logic [KEY_AW-1:0]   r_cnt;
  logic [KEY_AW-1:0]   w_cnt_nxt;
  logic [BLK_W-1:0]    r_state;
  logic [BLK_W-1:0]    w_state_nxt;
  logic [BLK_W-1:0]    r_out;
  logic [BLK_W-1:0]    w_out_nxt;
  logic                r_done;
  logic                w_done_nxt;

  logic [BLK_W-1:0]    w_isb;
  logic [BLK_W-1:0]    w_ark;
  logic [BLK_W-1:0]    w_imc;

  // InvShiftRows folded into the S-box input: byte (row, col) takes (row, col-row)
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int unsigned ROW = i % 4;
    localparam int unsigned COL = i / 4;
    localparam int unsigned SRC = ROW + 4 * ((COL + 4 - ROW) % 4);
    assign w_isb[127-8*i -: 8] = INV_SBOX[r_state[127-8*SRC -: 8]];
  end

  assign w_ark = w_isb ^ round_key;

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_ark[127-32*c -: 8];
    assign w_a1 = w_ark[119-32*c -: 8];
    assign w_a2 = w_ark[111-32*c -: 8];
    assign w_a3 = w_ark[103-32*c -: 8];
    assign w_imc[127-32*c -: 8] = mule(w_a0) ^ mulb(w_a1) ^ muld(w_a2) ^ mul9(w_a3);
    assign w_imc[119-32*c -: 8] = mul9(w_a0) ^ mule(w_a1) ^ mulb(w_a2) ^ muld(w_a3);
    assign w_imc[111-32*c -: 8] = muld(w_a0) ^ mul9(w_a1) ^ mule(w_a2) ^ mulb(w_a3);
    assign w_imc[103-32*c -: 8] = mulb(w_a0) ^ muld(w_a1) ^ mul9(w_a2) ^ mule(w_a3);
  end

  // Next-state and datapath select; every transition out of IDLE/ROUND/FINAL waits on key ready
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_done_nxt  = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (En && round_key_rdy) begin
          w_state_nxt = data_in ^ round_key;
          w_cnt_nxt   = KEY_AW'(NR - 1);
          w_fsm_nxt   = S_ROUND;
        end
      end
      S_ROUND: begin
        if (round_key_rdy) begin
          w_state_nxt = w_imc;
          w_cnt_nxt   = r_cnt - KEY_AW'(1);
          if (r_cnt == KEY_AW'(1)) begin
            w_fsm_nxt = S_FINAL;
          end
        end
      end
      S_FINAL: begin
        if (round_key_rdy) begin
          w_out_nxt  = w_ark;
          w_done_nxt = 1'b1;
          w_cnt_nxt  = KEY_AW'(NR);
          w_fsm_nxt  = S_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
        w_cnt_nxt = KEY_AW'(NR);
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_fsm   <= S_IDLE;
      r_cnt   <= KEY_AW'(NR);
      r_state <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign data_out       = r_out;
  assign done           = r_done;
  assign round_key_addr = r_cnt;

endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: FIPS-197 vectors plus random blocks against a byte-level
// inverse-cipher model whose S-boxes are derived arithmetically from GF(2^8).
module tb_aes_decrypt;

  logic         Clk;
  logic         Rst;
  logic         En;
  logic [127:0] data_in;
  logic [127:0] round_key;
  logic         round_key_rdy;
  logic [127:0] data_out;
  logic         done;
  logic [3:0]   round_key_addr;

  logic [127:0] rk [16];
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  logic [127:0] last_pt;
  int           n_checks;
  int           n_errors;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decrypt dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .En             (En),
    .data_in        (data_in),
    .round_key      (round_key),
    .round_key_rdy  (round_key_rdy),
    .data_out       (data_out),
    .done           (done),
    .round_key_addr (round_key_addr)
  );

  assign round_key = rk[round_key_addr];

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    repeat (254) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] inv_cipher(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k;
    logic [127:0] res;
    k = rk[10];
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      k = rk[r];
      for (int i = 0; i < 16; i++)
        t[i] = isb[s[(i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)]] ^ k[127-8*i -: 8];
      for (int c = 0; c < 4; c++) begin
        if (r > 0) begin
          s[4*c]   = gmul(t[4*c], 14) ^ gmul(t[4*c+1], 11) ^ gmul(t[4*c+2], 13) ^ gmul(t[4*c+3], 9);
          s[4*c+1] = gmul(t[4*c], 9)  ^ gmul(t[4*c+1], 14) ^ gmul(t[4*c+2], 11) ^ gmul(t[4*c+3], 13);
          s[4*c+2] = gmul(t[4*c], 13) ^ gmul(t[4*c+1], 9)  ^ gmul(t[4*c+2], 14) ^ gmul(t[4*c+3], 11);
          s[4*c+3] = gmul(t[4*c], 11) ^ gmul(t[4*c+1], 13) ^ gmul(t[4*c+2], 9)  ^ gmul(t[4*c+3], 14);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Entered and left on a falling edge; leaves the bench in the done cycle
  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp_pt, input int stall_at,
                           input int n_stall, input bit wiggle_en, input string tag);
    int edges;
    int stalled;
    int exp_addr;
    bit adv;
    bit seen_done;
    check({tag, " idle_addr"}, 128'(round_key_addr), 128'(10));
    data_in       = ct;
    En            = 1'b1;
    round_key_rdy = 1'b1;
    @(posedge Clk);
    edges = 1;
    @(negedge Clk);
    En        = 1'b0;
    data_in   = {$urandom, $urandom, $urandom, $urandom};
    exp_addr  = 9;
    stalled   = 0;
    seen_done = 1'b0;
    while (edges < 40) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      check({tag, " addr"}, 128'(round_key_addr), 128'(exp_addr));
      check({tag, " hold"}, data_out, last_pt);
      adv = !(exp_addr == stall_at && stalled < n_stall);
      if (!adv) stalled++;
      round_key_rdy = adv;
      if (wiggle_en) En = 1'($urandom);
      @(posedge Clk);
      edges++;
      @(negedge Clk);
      if (adv && exp_addr > 0) exp_addr--;
    end
    round_key_rdy = 1'b1;
    En            = 1'b0;
    check({tag, " done_seen"}, 128'(seen_done), 128'(1));
    check({tag, " latency"}, 128'(edges), 128'(11 + n_stall));
    check({tag, " data_out"}, data_out, exp_pt);
    check({tag, " end_addr"}, 128'(round_key_addr), 128'(10));
    last_pt = exp_pt;
  endtask

  task automatic done_low(input string tag);
    @(negedge Clk);
    check({tag, " done_low"}, 128'(done), 128'(0));
  endtask

  initial begin
    logic [127:0] key;
    logic [127:0] ct;
    n_checks      = 0;
    n_errors      = 0;
    Clk           = 1'b0;
    Rst           = 1'b0;
    En            = 1'b0;
    round_key_rdy = 1'b0;
    data_in       = '0;
    last_pt       = '0;
    for (int i = 0; i < 16; i++) rk[i] = '0;
    for (int b = 0; b < 256; b++) begin
      sb[b]  = affine(ginv(8'(b)));
      isb[b] = ginv(inv_affine(8'(b)));
    end

    repeat (2) @(negedge Clk);
    check("rst addr", 128'(round_key_addr), 128'(10));
    check("rst data_out", data_out, 128'h0);
    check("rst done", 128'(done), 128'(0));
    Rst = 1'b1;
    @(negedge Clk);

    expand(C1_KEY);
    run_block(C1_CT, C1_PT, -1, 0, 1'b0, "c1");
    done_low("c1");

    expand(B_KEY);
    run_block(B_CT, B_PT, -1, 0, 1'b0, "appb");
    done_low("appb");

    expand(C1_KEY);
    run_block(C1_CT, C1_PT, 5, 3, 1'b0, "stall");
    done_low("stall");

    // En without key ready must not start
    En            = 1'b1;
    round_key_rdy = 1'b0;
    data_in       = B_CT;
    repeat (4) begin
      @(posedge Clk);
      @(negedge Clk);
      check("gate addr", 128'(round_key_addr), 128'(10));
      check("gate done", 128'(done), 128'(0));
    end
    En            = 1'b0;
    round_key_rdy = 1'b1;
    @(negedge Clk);
    check("gate data_out", data_out, last_pt);
    run_block(C1_CT, C1_PT, -1, 0, 1'b1, "en_wiggle");
    done_low("en_wiggle");

    run_block(C1_CT, C1_PT, -1, 0, 1'b0, "b2b_1");
    expand(B_KEY);
    run_block(B_CT, B_PT, -1, 0, 1'b0, "b2b_2");
    done_low("b2b");

    expand(C1_KEY);
    data_in       = C1_CT;
    En            = 1'b1;
    round_key_rdy = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    En = 1'b0;
    for (int i = 0; i < 20 && round_key_addr != 4'd4; i++) @(negedge Clk);
    check("rst_mid reached", 128'(round_key_addr), 128'(4));
    #2 Rst = 1'b0;
    #1;
    check("rst_mid data_out", data_out, 128'h0);
    check("rst_mid done", 128'(done), 128'(0));
    check("rst_mid addr", 128'(round_key_addr), 128'(10));
    last_pt = '0;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    run_block(C1_CT, C1_PT, -1, 0, 1'b0, "after_rst");
    done_low("after_rst");

    for (int n = 0; n < 6; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      expand(key);
      run_block(ct, inv_cipher(ct), int'($urandom_range(9, 0)), int'($urandom_range(3, 0)),
                1'b1, "rand");
      done_low("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
